// File: rtl/grf_sb.sv
// Register file with write-back bypass and per-register pending-write counters for RAW hazard detection.
// Reads are combinational with zero latency; issue is refused while a destination counter is saturated.
module grf_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int CNT_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic                  iss_ready,
  output logic                  pend_any
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] regs [DEPTH];
  logic [CNT_W-1:0]  cnt  [DEPTH];

  logic wr_live;
  logic iss_fire;

  assign wr_live  = wr_en && (wr_addr != '0);
  assign iss_fire = iss_valid && iss_ready;

  // A saturated producer count still admits a new issue when a write-back drains it this cycle.
  assign iss_ready = !reset && ((iss_addr == '0) || (cnt[iss_addr] != CNT_MAX) ||
                                (wr_en && (wr_addr == iss_addr)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < DEPTH; a++) begin
        regs[a] <= '0;
        cnt[a]  <= '0;
      end
    end else begin
      if (wr_live) regs[wr_addr] <= wr_data;
      for (int a = 1; a < DEPTH; a++) begin
        logic inc;
        logic dec;
        inc = iss_fire && (iss_addr == ADDR_W'(a));
        dec = wr_en && (wr_addr == ADDR_W'(a)) && (cnt[a] != '0);
        if (inc && !dec)      cnt[a] <= cnt[a] + CNT_W'(1);
        else if (dec && !inc) cnt[a] <= cnt[a] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      logic [ADDR_W-1:0] ra;
      logic              hit;
      ra  = rd_addr[k*ADDR_W +: ADDR_W];
      hit = wr_en && (wr_addr == ra);
      if (!reset && (ra != '0)) begin
        rd_data[k*DATA_W +: DATA_W] = hit ? wr_data : regs[ra];
        // The last outstanding producer being bypassed clears the hazard this same cycle.
        rd_busy[k] = (cnt[ra] != '0) && !(hit && (cnt[ra] == CNT_W'(1)));
      end
    end
  end

  always_comb begin
    pend_any = 1'b0;
    for (int a = 1; a < DEPTH; a++) begin
      if (cnt[a] != '0) pend_any = 1'b1;
    end
  end

endmodule

// File: tb/tb_grf_sb.sv
// Directed bench for grf_sb: bypass, r0 handling, counter saturation/drain and asynchronous reset.
module tb_grf_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;
  localparam int CNT_W  = 2;

  logic                  clk;
  logic                  reset;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  iss_valid;
  logic [ADDR_W-1:0]     iss_addr;
  logic                  iss_ready;
  logic                  pend_any;

  int n_checks;
  int n_errors;

  grf_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .pend_any  (pend_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and return on the falling edge, where inputs change.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic idle();
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    iss_valid = 1'b0;
    iss_addr  = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    idle();
    set_rd(5'd5, 5'd0);
    #1;
    check("rst_rd_data", rd_data, 64'h0);
    check("rst_rd_busy", rd_busy, 2'b00);
    check("rst_iss_ready", iss_ready, 1'b0);
    check("rst_pend_any", pend_any, 1'b0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    // 1: post-reset reads
    check("t1_rd_data", rd_data, 64'h0);
    check("t1_rd_busy", rd_busy, 2'b00);
    check("t1_iss_ready", iss_ready, 1'b1);

    // 2: bypass then stored value
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
    set_rd(5'd3, 5'd5);
    #1;
    check("t2_bypass", rd_data[31:0], 32'hDEADBEEF);
    check("t2_unrelated_port", rd_data[63:32], 32'h0);
    tick();
    idle();
    #1;
    check("t2_stored", rd_data[31:0], 32'hDEADBEEF);
    check("t2_busy", rd_busy, 2'b00);

    // 3: writes to r0 are discarded
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    set_rd(5'd0, 5'd3);
    #1;
    check("t3_r0_bypass_blocked", rd_data[31:0], 32'h0);
    tick();
    idle();
    #1;
    check("t3_r0_read", rd_data[31:0], 32'h0);
    check("t3_r0_busy", rd_busy, 2'b00);
    check("t3_pend_any", pend_any, 1'b0);

    // 4: saturate addr 7, then drain
    iss_valid = 1'b1; iss_addr = 5'd7;
    set_rd(5'd7, 5'd7);
    #1;
    check("t4_ready_cnt0", iss_ready, 1'b1);
    tick();
    tick();
    #1;
    check("t4_ready_cnt2", iss_ready, 1'b1);
    check("t4_busy_cnt2", rd_busy, 2'b11);
    @(negedge clk);
    iss_valid = 1'b0;
    #1;
    check("t4_ready_sat", iss_ready, 1'b0);
    check("t4_busy_sat", rd_busy, 2'b11);
    check("t4_pend_any", pend_any, 1'b1);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h70;
    #1;
    check("t4_ready_drain", iss_ready, 1'b1);
    check("t4_busy_cnt3_wb", rd_busy, 2'b11);
    tick();
    wr_en = 1'b0;
    #1;
    check("t4_ready_cnt2b", iss_ready, 1'b1);
    check("t4_busy_cnt2b", rd_busy, 2'b11);
    wr_en = 1'b1; wr_data = 32'h71;
    tick();
    wr_data = 32'h72;
    #1;
    check("t4_last_busy", rd_busy, 2'b00);
    check("t4_last_bypass", rd_data[31:0], 32'h72);
    tick();
    idle();
    #1;
    check("t4_pend_clear", pend_any, 1'b0);
    check("t4_stored", rd_data[63:32], 32'h72);

    // 5: simultaneous issue and write-back on addr 9 with cnt = 1
    iss_valid = 1'b1; iss_addr = 5'd9;
    set_rd(5'd9, 5'd0);
    tick();
    iss_valid = 1'b1; iss_addr = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    #1;
    check("t5_ready", iss_ready, 1'b1);
    check("t5_busy_bypass", rd_busy[0], 1'b0);
    tick();
    idle();
    #1;
    check("t5_pend_any", pend_any, 1'b1);
    check("t5_busy_after", rd_busy[0], 1'b1);
    check("t5_data", rd_data[31:0], 32'h99);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9A;
    tick();
    idle();
    #1;
    check("t5_drained", pend_any, 1'b0);

    // 6: asynchronous reset with producers in flight
    iss_valid = 1'b1; iss_addr = 5'd4;
    set_rd(5'd4, 5'd3);
    tick();
    tick();
    iss_valid = 1'b0;
    #1;
    check("t6_busy_before", rd_busy, 2'b01);
    check("t6_pend_before", pend_any, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_data", rd_data, 64'h0);
    check("t6_rst_busy", rd_busy, 2'b00);
    check("t6_rst_ready", iss_ready, 1'b0);
    check("t6_rst_pend", pend_any, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_post_pend", pend_any, 1'b0);
    check("t6_post_busy", rd_busy, 2'b00);
    check("t6_post_r3_cleared", rd_data[63:32], 32'h0);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
    tick();
    idle();
    #1;
    check("t6_untracked_pend", pend_any, 1'b0);
    check("t6_untracked_busy", rd_busy, 2'b00);
    check("t6_untracked_data", rd_data[31:0], 32'h44);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
